// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared codes, limits and FSM state for the instruction encoder
package instr_enc_pkg;
    typedef enum logic [2:0] {T_I = 3'b000, T_S, T_B, T_J, T_U, T_R} imm_type_t;
    typedef enum logic [1:0] {ERR_OK, ERR_RANGE, ERR_ALIGN, ERR_TYPE} err_t;
    typedef enum logic [1:0] {IDLE, CHECK, EMIT} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;
    function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
        return v >= lo && v <= hi;
    endfunction
endpackage

// File: rtl/instr_encoder_imm_pack.sv
// imm_pack: packs decoded fields into an RV32I word and flags immediate errors
module imm_pack
    import instr_enc_pkg::*;
(
    input  logic [2:0]  imm_type,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic [1:0]  err
);
    logic [31:0] raw;
    always_comb begin
        raw = NOP;
        err = ERR_OK;
        case (imm_type)
            T_I: begin
                raw = {imm[11:0], rs1, funct3, rd, opcode};
                err = in_range(imm, IMM12_MIN, IMM12_MAX) ? ERR_OK : ERR_RANGE;
            end
            T_S: begin
                raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err = in_range(imm, IMM12_MIN, IMM12_MAX) ? ERR_OK : ERR_RANGE;
            end
            T_B: begin
                raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err = imm[0] ? ERR_ALIGN : in_range(imm, IMM13_MIN, IMM13_MAX) ? ERR_OK : ERR_RANGE;
            end
            T_J: begin
                raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err = imm[0] ? ERR_ALIGN : in_range(imm, IMM21_MIN, IMM21_MAX) ? ERR_OK : ERR_RANGE;
            end
            T_U: begin
                raw = {imm[31:12], rd, opcode};
                err = |imm[11:0] ? ERR_ALIGN : ERR_OK;
            end
            T_R: raw = {funct7, rs2, rs1, funct3, rd, opcode};
            default: err = ERR_TYPE;
        endcase
    end
    // any rejected bundle becomes a harmless NOP
    assign instr = (err == ERR_OK) ? raw : NOP;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: handshaked RV32I packer that emits words with a write address
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        imm_type,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [1:0]        out_err,
    output logic              addr_ovf
);
    state_t state, next_state;
    logic [2:0] r_type, r_f3;
    logic [6:0] r_op, r_f7;
    logic [4:0] r_rd, r_rs1, r_rs2;
    logic [31:0] r_imm, p_instr;
    logic [1:0] p_err;
    logic done;
    assign done = state == EMIT && out_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = CHECK;
            CHECK:   next_state = EMIT;
            EMIT:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == EMIT;
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            {r_type, r_op, r_rd, r_rs1, r_rs2} <= {imm_type, opcode, rd, rs1, rs2};
            {r_f3, r_f7, r_imm} <= {funct3, funct7, imm};
        end
    end
    imm_pack u_pack (
        .imm_type(r_type),
        .opcode  (r_op),
        .rd      (r_rd),
        .rs1     (r_rs1),
        .rs2     (r_rs2),
        .funct3  (r_f3),
        .funct7  (r_f7),
        .imm     (r_imm),
        .instr   (p_instr),
        .err     (p_err)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_instr <= '0;
            out_err   <= '0;
        end else if (state == CHECK) begin
            out_instr <= p_instr;
            out_err   <= p_err;
        end
    end
    // a clear landing on a handshake wins over the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_addr <= '0;
            addr_ovf <= 1'b0;
        end else if (addr_clr) begin
            out_addr <= '0;
            addr_ovf <= 1'b0;
        end else if (done && out_err == ERR_OK) begin
            out_addr <= out_addr + 1'b1;
            if (&out_addr) addr_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed checks of packing, errors, backpressure, wrap, clear and reset
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  imm_type = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        addr_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [1:0]  out_addr;
    logic [1:0]  out_err;
    logic        addr_ovf;
    int checks = 0;
    int failures = 0;

    instr_encoder #(.ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_type(imm_type), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .addr_clr(addr_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .addr_ovf(addr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dec_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] dec_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    // presents a bundle at a falling edge; returns one negedge after acceptance (FSM in CHECK)
    task automatic issue(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd_v,
                         input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm_v);
        @(negedge clk);
        {imm_type, opcode, rd, rs1, rs2, funct3, funct7, imm} = {t, op, rd_v, rs1_v, rs2_v, f3, f7, imm_v};
        in_valid = 1'b1;
        for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
        checks++;
        if (!in_ready) begin failures++; $display("FAIL issue_timeout in_ready=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        checks++;
        if (!out_valid) begin failures++; $display("FAIL valid_timeout out_valid=%b exp=1", out_valid); end
    endtask

    task automatic run(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd_v,
                       input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm_v);
        issue(t, op, rd_v, rs1_v, rs2_v, f3, f7, imm_v);
        wait_valid();
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", out_instr); end
        checks++; if (out_addr !== 2'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", out_addr); end
        checks++; if (out_err !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", out_err); end
        checks++; if (addr_ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", addr_ovf); end
    endtask

    task automatic test_addi();
        issue(3'b000, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -32'sd2041);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL addi_check_state valid=%b ready=%b exp=0,0", out_valid, in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_latency out_valid=%b exp=1", out_valid); end
        checks++; if (out_instr !== 32'h80710093) begin failures++; $display("FAIL addi_instr got=%h exp=80710093", out_instr); end
        checks++; if (out_err !== 2'b00) begin failures++; $display("FAIL addi_err got=%b exp=00", out_err); end
        checks++; if (out_addr !== 2'd0) begin failures++; $display("FAIL addi_addr got=%0d exp=0", out_addr); end
    endtask

    task automatic test_branch_jal();
        run(3'b010, 7'h63, 5'd0, 5'd2, 5'd3, 3'd0, 7'd0, -32'sd16);
        checks++; if (out_instr !== 32'hFE3108E3) begin failures++; $display("FAIL beq_instr got=%h exp=fe3108e3", out_instr); end
        checks++; if (dec_b(out_instr) !== -32'sd16) begin failures++; $display("FAIL beq_roundtrip got=%0d exp=-16", $signed(dec_b(out_instr))); end
        checks++; if (out_addr !== 2'd1) begin failures++; $display("FAIL beq_addr got=%0d exp=1", out_addr); end
        run(3'b011, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        checks++; if (out_instr !== 32'h001000EF) begin failures++; $display("FAIL jal_instr got=%h exp=001000ef", out_instr); end
        checks++; if (dec_j(out_instr) !== 32'd2048) begin failures++; $display("FAIL jal_roundtrip got=%0d exp=2048", $signed(dec_j(out_instr))); end
        checks++; if (out_addr !== 2'd2) begin failures++; $display("FAIL jal_addr got=%0d exp=2", out_addr); end
    endtask

    task automatic test_errors();
        run(3'b000, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
        checks++; if (out_instr !== 32'h13 || out_err !== 2'b01) begin failures++; $display("FAIL err_range instr=%h err=%b exp=00000013,01", out_instr, out_err); end
        checks++; if (out_addr !== 2'd3) begin failures++; $display("FAIL err_range_addr got=%0d exp=3", out_addr); end
        run(3'b010, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
        checks++; if (out_instr !== 32'h13 || out_err !== 2'b10) begin failures++; $display("FAIL err_b_align instr=%h err=%b exp=00000013,10", out_instr, out_err); end
        run(3'b100, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1001);
        checks++; if (out_instr !== 32'h13 || out_err !== 2'b10) begin failures++; $display("FAIL err_u_align instr=%h err=%b exp=00000013,10", out_instr, out_err); end
        run(3'b110, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        checks++; if (out_instr !== 32'h13 || out_err !== 2'b11) begin failures++; $display("FAIL err_type instr=%h err=%b exp=00000013,11", out_instr, out_err); end
        @(negedge clk);
        checks++; if (out_addr !== 2'd3 || addr_ovf !== 1'b0) begin failures++; $display("FAIL err_no_advance addr=%0d ovf=%b exp=3,0", out_addr, addr_ovf); end
    endtask

    task automatic test_lui_backpressure();
        out_ready = 1'b0;
        run(3'b100, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
        checks++; if (out_instr !== 32'h00001037 || out_addr !== 2'd3) begin failures++; $display("FAIL lui instr=%h addr=%0d exp=00001037,3", out_instr, out_addr); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_instr !== 32'h00001037 || out_addr !== 2'd3 || out_err !== 2'b00)
                begin failures++; $display("FAIL hold cyc=%0d valid=%b ready=%b instr=%h addr=%0d err=%b", i, out_valid, in_ready, out_instr, out_addr, out_err); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_addr !== 2'd0 || addr_ovf !== 1'b1) begin failures++; $display("FAIL wrap valid=%b addr=%0d ovf=%b exp=0,0,1", out_valid, out_addr, addr_ovf); end
    endtask

    task automatic test_after_wrap();
        run(3'b001, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, -32'sd4);
        checks++; if (out_instr !== 32'hFE512E23 || out_addr !== 2'd0) begin failures++; $display("FAIL sw instr=%h addr=%0d exp=fe512e23,0", out_instr, out_addr); end
        run(3'b000, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
        checks++; if (out_instr !== 32'h7FF00293 || out_err !== 2'b00 || out_addr !== 2'd1) begin failures++; $display("FAIL addi_max instr=%h err=%b addr=%0d exp=7ff00293,00,1", out_instr, out_err, out_addr); end
        checks++; if (addr_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", addr_ovf); end
    endtask

    task automatic test_clr_handshake();
        run(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        checks++; if (out_instr !== 32'h80000093 || out_addr !== 2'd2) begin failures++; $display("FAIL addi_min instr=%h addr=%0d exp=80000093,2", out_instr, out_addr); end
        addr_clr = 1'b1;
        @(negedge clk);
        addr_clr = 1'b0;
        checks++; if (out_addr !== 2'd0 || addr_ovf !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL clr_wins addr=%0d ovf=%b valid=%b exp=0,0,0", out_addr, addr_ovf, out_valid); end
    endtask

    task automatic test_reset_in_check();
        run(3'b000, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
        issue(3'b000, 7'h13, 5'd7, 5'd7, 5'd0, 3'd0, 7'd0, 32'd9);
        checks++; if (out_addr !== 2'd1) begin failures++; $display("FAIL pre_rst_addr got=%0d exp=1", out_addr); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_addr !== 2'd0 || out_instr !== 32'h0) begin failures++; $display("FAIL rst_check valid=%b ready=%b addr=%0d instr=%h exp=0,1,0,0", out_valid, in_ready, out_addr, out_instr); end
        @(negedge clk);
        rst = 1'b0;
        run(3'b101, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF);
        checks++; if (out_instr !== 32'h002081B3 || out_err !== 2'b00 || out_addr !== 2'd0) begin failures++; $display("FAIL post_rst_add instr=%h err=%b addr=%0d exp=002081b3,00,0", out_instr, out_err, out_addr); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_addi();
        test_branch_jal();
        test_errors();
        test_lui_backpressure();
        test_after_wrap();
        test_clr_handshake();
        test_reset_in_check();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
